instr_line_fetch_mem: RTL and testbench
=======================================

Name: instr_line_fetch_mem

Overview:
- Parametrised, writable instruction memory; successor to the fixed 3-word instruction ROM.
- Sits on the shared 16-bit memory-mapped bus at unit ID InstrMemEn (2) and feeds the execution engine's data multiplexor.
- Adds a loader write port, configurable depth and word width, and multi-word line fetch with wrap-around.
- Line fetch stops early at a STOP instruction (all ones) and uses a small fill state machine.

Parameters:
- INSTR_W, 32, instruction word width in bits.
- DEPTH, 256, number of instruction words; must be a power of two, 2..4096.
- FETCH_WORDS, 8, instructions returned per fetch line (8x32 = 256-bit line).
- UNIT_ID, 2, value of address[15:12] that selects this unit.
- STOP_WORD, all ones (INSTR_W bits), STOP instruction encoding.

Ports:
- Clk  input  1  system clock; all state updates on falling edge.
- nReset  input  1  asynchronous, active-low reset.
- address  input  16  [15:12] unit select; [11:0] local word index.
- nRead  input  1  active-low read/fetch request.
- nWrite  input  1  active-low write request.
- Datain  input  INSTR_W  instruction word to write.
- Dataout  output  FETCH_WORDS*INSTR_W  fetched line; word k at [k*INSTR_W +: INSTR_W]; word 0 is the addressed instruction.
- DataValid  output  1  line complete and stable.
- Busy  output  1  fill in progress.
- StopFound  output  1  current line contains STOP_WORD.
- WordCount  output  $clog2(FETCH_WORDS+1)  words fetched in the line, including the STOP word.
- WrErr  output  1  one-cycle pulse when a write is rejected.

Behaviour:
- IDX_W = $clog2(DEPTH). The access is "selected" when address[15:12]==UNIT_ID. The access is "in range" when address[11:IDX_W]==0.
- Reset (async, immediate):
  - Dataout=0, DataValid=0, Busy=0, StopFound=0, WordCount=0, WrErr=0.
  - State=IDLE.
  - Every memory word = STOP_WORD.
  - Reset mid-fill aborts the fill with no partial output.
- FSM states: IDLE, FILL, DONE.
- IDLE, at each falling edge:
  - Selected, in range, nWrite=0: mem[address[IDX_W-1:0]] <= Datain. A simultaneous nRead=0 is deferred; write has priority.
  - Else selected, in range, nRead=0: capture base=address[IDX_W-1:0]. Set ptr=base, k=0, all Dataout slots=STOP_WORD, StopFound=0, WordCount=0, Busy=1 → FILL.
  - Selected, out-of-range write: WrErr=1 for one edge period, no write. Out-of-range read: ignored.
  - Not selected: no effect.
- FILL, at each falling edge:
  - Slot k <= mem[ptr]; WordCount=k+1; ptr=(ptr+1) mod DEPTH (wraps past DEPTH-1 to 0); k++.
  - If the word equals STOP_WORD: StopFound=1 and the fill ends immediately; remaining slots stay STOP_WORD.
  - Fill also ends when k reaches FETCH_WORDS.
  - On fill end, at the same edge: Busy=0, DataValid=1 → DONE.
  - Address and nRead changes during FILL are ignored; the fill always completes.
- Latency: word k lands on the (k+1)-th falling edge after the capture edge. A full line with no STOP is valid FETCH_WORDS edges after capture.
- DONE:
  - Dataout, StopFound and WordCount are held.
  - At the first falling edge sampling nRead=1 (or not selected): DataValid=0 → IDLE.
  - Dataout keeps its value until the next capture.
  - A held-low nRead does not refetch; it must rise before a new fetch.
- Writes: any selected nWrite=0 in FILL or DONE is dropped, WrErr pulses one period, memory unchanged.
- WrErr is otherwise 0. It is cleared at the next falling edge.

Test Plan (DEPTH=16, FETCH_WORDS=4, INSTR_W=32):
1. Release reset, fetch 0x2000.
   → Slot0 reads STOP.
   → DataValid at edge 1, WordCount=1, StopFound=1, Dataout all 0xFFFFFFFF.
2. Write 0x01020001, 0x03030201, 0x02030300, 0x030401FF, 0x04050380 to indices 0-4; fetch 0x2000.
   → Busy for 4 edges; DataValid at edge 4.
   → Dataout={0x030401FF,0x02030300,0x03030201,0x01020001}, WordCount=4, StopFound=0.
3. Write 0xAAAA0001 to idx14 and 0xAAAA0002 to idx15; fetch 0x200E.
   → Slots = idx14, idx15, idx0, idx1 (wrap-around).
4. Write 0xFFFFFFFF to idx2; fetch 0x2000.
   → DataValid at edge 3, WordCount=3, StopFound=1.
   → Slots 2 and 3 = 0xFFFFFFFF.
5. Write with nWrite=0 at 0x2005 during FILL → WrErr pulse, idx5 unchanged on refetch.
   - Write to 0x3005 → ignored, no WrErr.
   - Write to 0x2010 → WrErr.
   - nRead and nWrite both low in IDLE → write occurs, fetch starts next edge after nWrite rises.
6. Assert nReset after the second fill edge.
   → All outputs 0 immediately, state IDLE.
   → Subsequent fetch 0x2000 returns STOP line (memory cleared).

Source files
------------

// File: rtl/instr_line_fetch_mem.sv
// Writable instruction memory on the shared 16-bit memory-mapped bus.
// Returns a line of FETCH_WORDS instructions starting at the addressed word,
// wrapping past the last index and stopping early at the STOP instruction.
// All state advances on the falling edge of Clk; reset is asynchronous.
module instr_line_fetch_mem #(
  parameter int unsigned        INSTR_W     = 32,
  parameter int unsigned        DEPTH       = 256,
  parameter int unsigned        FETCH_WORDS = 8,
  parameter logic [3:0]         UNIT_ID     = 4'd2,
  parameter logic [INSTR_W-1:0] STOP_WORD   = '1
) (
  input  logic                                Clk,
  input  logic                                nReset,
  input  logic [15:0]                         address,
  input  logic                                nRead,
  input  logic                                nWrite,
  input  logic [INSTR_W-1:0]                  Datain,
  output logic [FETCH_WORDS*INSTR_W-1:0]      Dataout,
  output logic                                DataValid,
  output logic                                Busy,
  output logic                                StopFound,
  output logic [$clog2(FETCH_WORDS+1)-1:0]    WordCount,
  output logic                                WrErr
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(FETCH_WORDS+1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_FILL = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [INSTR_W-1:0] mem_q  [DEPTH];
  logic [INSTR_W-1:0] slot_q [FETCH_WORDS];
  logic [INSTR_W-1:0] slot_d [FETCH_WORDS];
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   wc_q, wc_d;
  logic               valid_q, valid_d;
  logic               busy_q, busy_d;
  logic               stop_q, stop_d;
  logic               wrerr_q, wrerr_d;

  logic               sel;
  logic               in_range;
  logic [11:0]        hi_bits;
  logic [IDX_W-1:0]   idx;
  logic [INSTR_W-1:0] rd_word;
  logic               mem_we;
  logic               fill_end;

  assign sel      = (address[15:12] == UNIT_ID);
  assign hi_bits  = address[11:0] >> IDX_W;
  assign in_range = (hi_bits == '0);
  assign idx      = address[IDX_W-1:0];
  assign rd_word  = mem_q[ptr_q];
  // The word count doubles as the slot index being filled.
  assign fill_end = (rd_word == STOP_WORD) || (wc_q == CNT_W'(FETCH_WORDS-1));

  // Next-state logic: write/fetch decode in IDLE, one word per edge in FILL.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wc_d    = wc_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    stop_d  = stop_q;
    wrerr_d = 1'b0;
    mem_we  = 1'b0;
    for (int unsigned i = 0; i < FETCH_WORDS; i++) slot_d[i] = slot_q[i];

    case (state_q)
      S_IDLE: begin
        if (sel && !nWrite) begin
          if (in_range) mem_we = 1'b1;
          else          wrerr_d = 1'b1;
        end else if (sel && in_range && !nRead) begin
          ptr_d  = idx;
          wc_d   = '0;
          stop_d = 1'b0;
          busy_d = 1'b1;
          for (int unsigned i = 0; i < FETCH_WORDS; i++) slot_d[i] = STOP_WORD;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (sel && !nWrite) wrerr_d = 1'b1;
        for (int unsigned i = 0; i < FETCH_WORDS; i++)
          if (wc_q == CNT_W'(i)) slot_d[i] = rd_word;
        wc_d  = wc_q + 1'b1;
        ptr_d = ptr_q + 1'b1;
        if (rd_word == STOP_WORD) stop_d = 1'b1;
        if (fill_end) begin
          busy_d  = 1'b0;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (sel && !nWrite) wrerr_d = 1'b1;
        if (nRead || !sel) begin
          valid_d = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Instruction storage; reset fills every word with STOP.
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= STOP_WORD;
    end else if (mem_we) begin
      mem_q[idx] <= Datain;
    end
  end

  // Control and line registers.
  always_ff @(negedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      wc_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      stop_q  <= 1'b0;
      wrerr_q <= 1'b0;
      for (int unsigned i = 0; i < FETCH_WORDS; i++) slot_q[i] <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wc_q    <= wc_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      stop_q  <= stop_d;
      wrerr_q <= wrerr_d;
      for (int unsigned i = 0; i < FETCH_WORDS; i++) slot_q[i] <= slot_d[i];
    end
  end

  // Pack the line slots onto the output bus, word 0 in the low bits.
  always_comb begin
    Dataout = '0;
    for (int unsigned i = 0; i < FETCH_WORDS; i++)
      Dataout[i*INSTR_W +: INSTR_W] = slot_q[i];
  end

  assign DataValid = valid_q;
  assign Busy      = busy_q;
  assign StopFound = stop_q;
  assign WordCount = wc_q;
  assign WrErr     = wrerr_q;

endmodule

// File: tb/tb_instr_line_fetch_mem.sv
// Directed bench for instr_line_fetch_mem with DEPTH=16, FETCH_WORDS=4, INSTR_W=32.
module tb_instr_line_fetch_mem;

  localparam logic [31:0] STOP = 32'hFFFF_FFFF;

  logic         Clk, nReset, nRead, nWrite;
  logic [15:0]  address;
  logic [31:0]  Datain;
  logic [127:0] Dataout;
  logic         DataValid, Busy, StopFound, WrErr;
  logic [2:0]   WordCount;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [127:0] line;
    logic [2:0]   wc;
    logic         stop;
    int           edges;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mdl [16];

  instr_line_fetch_mem #(
    .INSTR_W(32),
    .DEPTH(16),
    .FETCH_WORDS(4),
    .UNIT_ID(4'd2)
  ) dut (
    .Clk(Clk),
    .nReset(nReset),
    .address(address),
    .nRead(nRead),
    .nWrite(nWrite),
    .Datain(Datain),
    .Dataout(Dataout),
    .DataValid(DataValid),
    .Busy(Busy),
    .StopFound(StopFound),
    .WordCount(WordCount),
    .WrErr(WrErr)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_line(input logic [3:0] base);
    exp_t e;
    logic [31:0] w;
    e.line = '1;
    e.wc   = '0;
    e.stop = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (!e.stop) begin
        w = mdl[4'(int'(base) + k)];
        e.line[k*32 +: 32] = w;
        e.wc = 3'(k + 1);
        if (w == STOP) e.stop = 1'b1;
      end
    end
    e.edges = int'(e.wc);
    return e;
  endfunction

  task automatic do_write(input logic [15:0] a, input logic [31:0] d);
    logic s, inr;
    s   = (a[15:12] == 4'h2);
    inr = (a[11:4] == 8'h00);
    @(posedge Clk);
    address = a; Datain = d; nWrite = 1'b0;
    @(posedge Clk);
    nWrite = 1'b1;
    chk("wrerr_on_write", 128'(WrErr), 128'(s && !inr));
    if (s && inr) mdl[a[3:0]] = d;
  endtask

  // Issue a fetch, optionally disturb it with a write during FILL, or start
  // it together with a write (write must win, fetch follows once nWrite rises).
  task automatic fetch(input logic [15:0] a, input bit disturb, input bit prewrite,
                       input logic [31:0] pdata);
    exp_t e;
    int   n;
    bit   done;
    @(posedge Clk);
    address = a; nRead = 1'b0;
    if (prewrite) begin
      Datain = pdata; nWrite = 1'b0;
      @(posedge Clk);
      chk("simul_write_no_fetch", 128'(Busy), 128'(0));
      mdl[a[3:0]] = pdata;
      nWrite = 1'b1;
    end
    sb.push_back(model_line(a[3:0]));
    @(posedge Clk);
    chk("busy_at_capture", 128'(Busy), 128'(1));
    chk("novalid_at_capture", 128'(DataValid), 128'(0));
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      if (disturb && n == 0) begin address = 16'h2005; Datain = 32'h1234_5678; nWrite = 1'b0; end
      if (disturb && n == 1) nWrite = 1'b1;
      @(posedge Clk);
      n++;
      if (disturb && n == 1) chk("wrerr_in_fill", 128'(WrErr), 128'(1));
      if (disturb && n == 2) chk("wrerr_cleared", 128'(WrErr), 128'(0));
      if (DataValid) done = 1'b1;
    end
    chk("fill_completed", 128'(done), 128'(1));
    if (sb.size() == 0) begin
      chk("scoreboard_nonempty", 128'(0), 128'(1));
    end else begin
      e = sb.pop_front();
      chk("fill_edges", 128'(n), 128'(e.edges));
      chk("line_data", Dataout, e.line);
      chk("word_count", 128'(WordCount), 128'(e.wc));
      chk("stop_found", 128'(StopFound), 128'(e.stop));
      chk("busy_clear_at_valid", 128'(Busy), 128'(0));
    end
    nRead = 1'b1; nWrite = 1'b1;
    @(posedge Clk);
    chk("valid_drop", 128'(DataValid), 128'(0));
  endtask

  initial begin
    nReset = 1'b0; nRead = 1'b1; nWrite = 1'b1;
    address = '0; Datain = '0;
    for (int i = 0; i < 16; i++) mdl[i] = STOP;
    #12;
    chk("rst_dataout", Dataout, 128'(0));
    chk("rst_flags", {125'(0), DataValid, Busy, StopFound}, 128'(0));
    chk("rst_wc_wrerr", {124'(0), WordCount, WrErr}, 128'(0));
    @(posedge Clk);
    nReset = 1'b1;

    // 1: empty memory yields a STOP line after one edge
    fetch(16'h2000, 1'b0, 1'b0, '0);

    // 2: program five words, full line without STOP
    do_write(16'h2000, 32'h0102_0001);
    do_write(16'h2001, 32'h0303_0201);
    do_write(16'h2002, 32'h0203_0300);
    do_write(16'h2003, 32'h0304_01FF);
    do_write(16'h2004, 32'h0405_0380);
    fetch(16'h2000, 1'b0, 1'b0, '0);
    chk("t2_line_const", Dataout, 128'h0304_01FF_0203_0300_0303_0201_0102_0001);

    // 3: wrap-around past the last index
    do_write(16'h200E, 32'hAAAA_0001);
    do_write(16'h200F, 32'hAAAA_0002);
    fetch(16'h200E, 1'b0, 1'b0, '0);
    chk("t3_line_const", Dataout, 128'h0303_0201_0102_0001_AAAA_0002_AAAA_0001);

    // 4: early STOP at slot 2
    do_write(16'h2002, STOP);
    fetch(16'h2000, 1'b0, 1'b0, '0);

    // 5: rejected and ignored writes, write/read collision
    fetch(16'h2003, 1'b1, 1'b0, '0);
    fetch(16'h2005, 1'b0, 1'b0, '0);
    do_write(16'h3005, 32'h5555_5555);
    do_write(16'h2010, 32'h6666_6666);
    fetch(16'h2005, 1'b0, 1'b0, '0);
    fetch(16'h2006, 1'b0, 1'b1, 32'hCAFE_0006);

    // 6: reset in the middle of a fill
    @(posedge Clk);
    address = 16'h2000; nRead = 1'b0;
    @(posedge Clk);
    chk("t6_busy_at_capture", 128'(Busy), 128'(1));
    @(posedge Clk);
    @(posedge Clk);
    #2 nReset = 1'b0;
    #1;
    chk("t6_rst_dataout", Dataout, 128'(0));
    chk("t6_rst_flags", {125'(0), DataValid, Busy, StopFound}, 128'(0));
    chk("t6_rst_wc_wrerr", {124'(0), WordCount, WrErr}, 128'(0));
    nRead = 1'b1;
    @(posedge Clk);
    nReset = 1'b1;
    for (int i = 0; i < 16; i++) mdl[i] = STOP;
    fetch(16'h2000, 1'b0, 1'b0, '0);
    chk("t6_line_all_stop", Dataout, {128{1'b1}});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
